// File: rtl/cla_adder_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry look-ahead adder
// among NREQ requesters; the result is registered with the winner ID.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot grant)
//   req_a/req_b       packed 16-bit operands, requester i at [16*i+:16]
//   req_cin           per-requester carry-in
//   res_valid/ready   response handshake
//   res_sum/cout/id   registered sum, carry-out, owner index

module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] ci;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cg;

  assign p = a ^ b;
  assign g = a & b;

  // Group carries are fully expanded so no carry depends on another.
  assign cg[0] = cin;
  assign cg[1] = gg[0] | (gp[0] & cin);
  assign cg[2] = gg[1] | (gp[1] & gg[0])
               | (gp[1] & gp[0] & cin);
  assign cg[3] = gg[2] | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign cg[4] = gg[3] | (gp[3] & gg[2])
               | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;
    assign gg[j] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[j] = &p[B+3:B];
    assign ci[B]   = cg[j];
    assign ci[B+1] = g[B] | (p[B] & cg[j]);
    assign ci[B+2] = g[B+1] | (p[B+1] & g[B])
                   | (p[B+1] & p[B] & cg[j]);
    assign ci[B+3] = g[B+2] | (p[B+2] & g[B+1])
                   | (p[B+2] & p[B+1] & g[B])
                   | (p[B+2] & p[B+1] & p[B] & cg[j]);
  end

  assign sum  = p ^ ci;
  assign cout = cg[4];

endmodule

module cla_adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_sum,
  output logic               res_cout,
  output logic [IDW-1:0]     res_id
);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  nxt_ptr;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            can_accept;
  logic [15:0]     add_a;
  logic [15:0]     add_b;
  logic            add_cin;
  logic [15:0]     add_sum;
  logic            add_cout;
  int              idx;

  assign can_accept = !res_valid || res_ready;

  // Search from rr_ptr upward, wrapping at NREQ.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = rst ? '0 : grant;

  assign add_a   = req_a[16*gidx +: 16];
  assign add_b   = req_b[16*gidx +: 16];
  assign add_cin = req_cin[gidx];

  carry_look_ahead_16bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign nxt_ptr = (gidx == IDW'(NREQ - 1)) ? '0
                 : gidx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (found) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_id    <= gidx;
      rr_ptr    <= nxt_ptr;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_adder_rr_arbiter.sv
// Directed bench for cla_adder_rr_arbiter with NREQ=4.
// Inputs change at negedge; outputs are sampled #1 after edges.

module tb_cla_adder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_cin;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sum;
  logic        res_cout;
  logic [1:0]  res_id;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  cla_adder_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = c;
  endtask

  task automatic res(input string tag, input logic [15:0] s,
                     input logic co, input logic [1:0] id);
    chk({tag, "_v"}, 32'(res_valid), 32'd1);
    chk({tag, "_sum"}, 32'(res_sum), 32'(s));
    chk({tag, "_cout"}, 32'(res_cout), 32'(co));
    chk({tag, "_id"}, 32'(res_id), 32'(id));
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic neg1();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    #12;
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_v", 32'(res_valid), 32'h0);
    chk("rst_sum", 32'(res_sum), 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);

    // single requester 0
    @(negedge clk);
    rst = 1'b0;
    setop(0, 16'd2, 16'd2, 1'b1);
    #1;
    chk("s0_rdy", 32'(req_ready), 32'h1);
    edge1();
    res("s0", 16'd5, 1'b0, 2'd0);
    setop(0, 16'd18, 16'd18, 1'b0);
    #1;
    chk("s1_rdy", 32'(req_ready), 32'h1);
    edge1();
    res("s1", 16'd36, 1'b0, 2'd0);

    // async reset while a response is pending
    req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_v", 32'(res_valid), 32'h0);
    chk("ar_sum", 32'(res_sum), 32'h0);
    chk("ar_rdy", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_first", 32'(req_ready), 32'h2);

    // all four, pointer still 0 since no edge granted
    req_valid = 4'b1111;
    setop(0, 16'd2, 16'd3, 1'b1);
    setop(1, 16'd100, 16'd0, 1'b1);
    setop(2, 16'd18, 16'd18, 1'b0);
    setop(3, 16'hFFFF, 16'h0001, 1'b0);
    #1;
    chk("a0_rdy", 32'(req_ready), 32'h1);
    edge1();
    res("a0", 16'd6, 1'b0, 2'd0);
    chk("a1_rdy", 32'(req_ready), 32'h2);
    edge1();
    res("a1", 16'd101, 1'b0, 2'd1);
    chk("a2_rdy", 32'(req_ready), 32'h4);
    edge1();
    res("a2", 16'd36, 1'b0, 2'd2);
    chk("a3_rdy", 32'(req_ready), 32'h8);
    edge1();
    res("a3", 16'd0, 1'b1, 2'd3);

    // fairness between 0 and 2
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("f_rdy", 32'(req_ready),
          (k % 2 == 0) ? 32'h1 : 32'h4);
      edge1();
      chk("f_id", 32'(res_id),
          (k % 2 == 0) ? 32'd0 : 32'd2);
      chk("f_sum", 32'(res_sum),
          (k % 2 == 0) ? 32'd6 : 32'd36);
    end

    // backpressure, last result id 2 sum 36
    @(negedge clk);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'(req_ready), 32'h0);
      edge1();
      res("bp", 16'd36, 1'b0, 2'd2);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(req_ready), 32'h1);
    edge1();
    res("bp_rel", 16'd6, 1'b0, 2'd0);

    // boundary operands on requester 0
    req_valid = 4'b0001;
    setop(0, 16'hFFFF, 16'hFFFF, 1'b1);
    #1;
    chk("b0_rdy", 32'(req_ready), 32'h1);
    edge1();
    res("b0", 16'hFFFF, 1'b1, 2'd0);
    setop(0, 16'h0, 16'h0, 1'b0);
    edge1();
    res("b1", 16'h0, 1'b0, 2'd0);
    req_valid = 4'b0000;
    edge1();
    chk("drain_v", 32'(res_valid), 32'h0);
    chk("drain_sum", 32'(res_sum), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cla_adder_rr_arbiter.md
Name: cla_adder_rr_arbiter

Overview:
- Shares one instance of the existing 16-bit carry look-ahead adder (carry_look_ahead_16bit) between NREQ requesters.
- Round-robin arbitration, one grant per cycle; the granted operands are added in the same cycle.
- Result is registered with the winner's ID and presented on a valid/ready response port.
- Sits between several datapath clients and the single shared adder; removes duplicate adders from the top level.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*16  operand A, requester i in bits [16*i+15:16*i].
- req_b  input  NREQ*16  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_ready  output  NREQ  one-hot grant; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
- res_valid  output  1  response valid.
- res_ready  input  1  response consumer ready.
- res_sum  output  16  registered sum.
- res_cout  output  1  registered carry-out.
- res_id  output  IDW  index of the requester that owns the response.

Behaviour:
- Reset (async, immediate): res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=0. While rst=1, req_ready=0.
- Accept condition: can_accept = !res_valid || res_ready.
- req_ready is combinational. It is all-zero when can_accept=0 or req_valid=0.
- Otherwise exactly one bit is set: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
- Datapath: the granted requester's a, b and cin are muxed into the single carry_look_ahead_16bit instance. No other adder is permitted.
- On a clock edge with a grant to g:
  - res_sum <= adder sum; res_cout <= adder cout.
  - res_id <= g; res_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- On a clock edge with no grant:
  - If res_valid && res_ready, then res_valid <= 0.
  - Otherwise res_valid holds.
  - res_sum, res_cout and res_id always hold.
- Latency: the request is accepted in cycle T; the response is valid in cycle T+1.
- Throughput: one op per cycle while res_ready=1.
- Backpressure: while res_valid=1 and res_ready=0:
  - No grants are issued.
  - The response registers hold stable.
  - rr_ptr holds.
- Simultaneous response consume and new grant in the same cycle: the new result replaces the old one and res_valid stays 1. No bubble.
- Requesters must hold a, b and cin stable while valid and not granted. Dropping valid before grant is allowed; no state is kept for that requester.
- Arithmetic: {res_cout,res_sum} = a + b + cin, full 17-bit result. Overflow wraps into res_cout.
- Fairness: a continuously requesting client waits at most NREQ-1 grants.
- Reset mid-operation: a pending response is discarded and rr_ptr returns to 0. The first grant after reset release goes to the lowest valid index.
- rr_ptr only advances on a grant; idle cycles do not move it.

Test Plan:
- Reset: assert rst mid-stream with res_valid=1 -> outputs go to zero immediately. After release, requests 1 and 3 both valid -> req_ready=4'b0010 first.
- Single requester 0: a=2, b=2, cin=1 -> next cycle res_valid=1, res_sum=5, res_cout=0, res_id=0. Then a=18, b=18, cin=0 -> res_sum=36.
- All 4 valid with res_ready=1 and operands (2,3,1), (100,0,1), (18,18,0), (0xFFFF,0x0001,0):
  - Grant order is 0,1,2,3, back-to-back.
  - Responses are 6, 101, 36, then sum=0 with cout=1 and id=3.
- Fairness: requesters 0 and 2 held valid for 6 grants -> grants alternate 0,2,0,2,0,2.
- Backpressure: res_ready=0 for 3 cycles with requests pending:
  - req_ready=0 and the response stays stable throughout.
  - With res_ready=1, the next grant occurs in the same cycle as the consume, with no idle cycle.
- Boundary: a=0xFFFF, b=0xFFFF, cin=1 -> res_sum=0xFFFF, res_cout=1. Then a=0, b=0, cin=0 -> res_sum=0, res_cout=0.
